mt_motion_ctrl: RTL and testbench
=================================

MT_MOTION_CTRL -- requirements
Module: mt_motion_ctrl

Interface
REQ-001 Parameter ACCEL, default 4, cycles spent accelerating before motion.
REQ-002 Parameter DECEL, default 3, cycles spent slowing down after motion.
REQ-003 Parameter RECTIME, default 8, cycles per record passed during space, erase or write-tape-mark.
REQ-004 Parameter EOTPOS, default 2400, record position at or beyond which end-of-tape is reported.
REQ-005 Clocking: clk input 1, clock; rst input 1, synchronous active-high reset.
REQ-006 mtINIT input 1: controller initialize, synchronous abort.
REQ-007 mtGO input 1: one-cycle function strobe.
REQ-008 mtFUN input 5: function code.
REQ-009 mtFCIN input 16: frame/record count, two's complement, sampled on GO.
REQ-010 mtMOL input 1: medium on-line.
REQ-011 mtWRL input 1: write lock.
REQ-012 mtTMREC input 1: the record just completed is a tape mark, sampled at record end.
REQ-013 mtDRY output 1: drive ready.
REQ-014 mtPIP output 1: positioning (rewind/unload) in progress.
REQ-015 mtSDWN output 1: slowing down.
REQ-016 mtBOT output 1: beginning of tape.
REQ-017 mtEOT output 1: end of tape.
REQ-018 mtTM output 1: tape mark detected or written.
REQ-019 mtFC output 16: live record count.
REQ-020 mtPOS output 16: tape position in records.
REQ-021 Error outputs, 1 bit each: mtILF illegal function; mtNEF non-executable function; mtFCE frame count error.
REQ-022 mtDONE output 1: one-cycle completion pulse, used to set attention.
REQ-023 mtOFFL output 1: one-cycle pulse at unload completion.

Function
REQ-024 Function codes: NOP=0, UNLOAD=1, REWIND=3, DRVCLR=4, ERASE=10, WRTM=11, SPCFWD=12, SPCREV=13; codes 16-31 are data functions and are ignored; all other codes are illegal.
REQ-025 State machine: IDLE, ACCEL, MOVE, DECEL, DONE; DONE lasts one cycle with mtDONE=1, then IDLE.
REQ-026 GO is accepted only in IDLE; GO in any other state is ignored with no status change.
REQ-027 NOP: no state change and no mtDONE.
REQ-028 DRVCLR: clears mtTM, mtILF, mtNEF and mtFCE next cycle; no mtDONE.
REQ-029 Illegal code: sets mtILF and enters DONE next cycle.
REQ-030 Motion code with mtMOL=0: sets mtNEF and enters DONE.
REQ-031 ERASE or WRTM with mtWRL=1: sets mtNEF and enters DONE.
REQ-032 SPCREV with mtPOS=0: enters DONE with no motion and no error.
REQ-033 Legal motion: mtFC loads mtFCIN (space only), mtTM clears, next state ACCEL for ACCEL cycles, then MOVE.
REQ-034 REWIND/UNLOAD in MOVE: mtPOS decrements by 1 per cycle until 0, then DECEL; UNLOAD pulses mtOFFL in its DONE cycle.
REQ-035 SPCFWD/SPCREV in MOVE: every RECTIME cycles, mtPOS increments (fwd) or decrements (rev) by 1 and mtFC increments by 1 (16-bit wrap).
REQ-036 Space termination, evaluated at record end: stop on mtFC==0, on mtTMREC=1 (also sets mtTM), or on SPCREV reaching mtPOS=0.
REQ-037 SPCREV stopping at BOT with mtFC!=0 sets mtFCE.
REQ-038 Passing EOTPOS does not stop motion.
REQ-039 ERASE and WRTM in MOVE: one record (RECTIME cycles), mtPOS+1; WRTM also sets mtTM; then DECEL.
REQ-040 DECEL lasts DECEL cycles with mtSDWN=1, then DONE.
REQ-041 mtDRY=1 only in IDLE.
REQ-042 mtPIP=1 in ACCEL, MOVE and DECEL of REWIND/UNLOAD.
REQ-043 mtBOT = mtMOL & (mtPOS==0); mtEOT = mtMOL & (mtPOS>=EOTPOS); mtPOS saturates at 0 and at 16'hFFFF.
REQ-044 mtMOL falling outside IDLE: abort to DONE next cycle, mtPOS=0, mtNEF set.
REQ-045 mtINIT: next state IDLE; clears mtTM, errors and mtFC; keeps mtPOS; no mtDONE; overrides simultaneous mtGO.

Reset
REQ-046 rst: state IDLE, mtPOS=0, mtFC=0, mtTM=mtILF=mtNEF=mtFCE=0, mtDONE=mtOFFL=0, mtSDWN=mtPIP=0, mtDRY=1.
REQ-047 rst has priority over mtINIT and mtGO.

Verification
REQ-048 Scenario: mtMOL=1, POS=0, GO SPCFWD, FCIN=16'hFFFD -> DRY low; after 4+3*8 cycles POS=3, FC=0; SDWN for 3 cycles; single DONE; DRY=1.
REQ-049 Scenario: POS=5, GO SPCREV, FCIN=16'hFFF6 -> stops at POS=0, BOT=1, FCE=1, FC=16'hFFFB, DONE once.
REQ-050 Scenario: SPCFWD FCIN=16'hFFF0, mtTMREC=1 at the second record end -> POS=2, TM=1, FC=16'hFFF2, DONE.
REQ-051 Scenario: mtWRL=1, GO WRTM -> NEF=1, POS unchanged, DONE next cycle; then GO DRVCLR -> NEF=0, no DONE.
REQ-052 Scenario: POS=10, GO UNLOAD -> PIP=1 throughout; POS=0; OFFL and DONE pulse together; GO during motion ignored.
REQ-053 Scenario: GO code 7 -> ILF=1 and DONE; mtINIT in MOVE of SPCFWD -> IDLE next cycle, DRY=1, POS retained, no DONE.

Source files
------------

// File: rtl/mt_motion_ctrl.sv
// Tape drive motion controller: function decode, accel/move/decel sequencing,
// record positioning with BOT/EOT and tape-mark status.
module mt_motion_ctrl #(
   parameter int ACCEL   = 4,
   parameter int DECEL   = 3,
   parameter int RECTIME = 8,
   parameter int EOTPOS  = 2400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mtINIT,
   input  logic        mtGO,
   input  logic [4:0]  mtFUN,
   input  logic [15:0] mtFCIN,
   input  logic        mtMOL,
   input  logic        mtWRL,
   input  logic        mtTMREC,
   output logic        mtDRY,
   output logic        mtPIP,
   output logic        mtSDWN,
   output logic        mtBOT,
   output logic        mtEOT,
   output logic        mtTM,
   output logic [15:0] mtFC,
   output logic [15:0] mtPOS,
   output logic        mtILF,
   output logic        mtNEF,
   output logic        mtFCE,
   output logic        mtDONE,
   output logic        mtOFFL
);

   localparam logic [4:0] F_NOP    = 5'd0;
   localparam logic [4:0] F_UNLOAD = 5'd1;
   localparam logic [4:0] F_REWIND = 5'd3;
   localparam logic [4:0] F_DRVCLR = 5'd4;
   localparam logic [4:0] F_ERASE  = 5'd10;
   localparam logic [4:0] F_WRTM   = 5'd11;
   localparam logic [4:0] F_SPCFWD = 5'd12;
   localparam logic [4:0] F_SPCREV = 5'd13;

   localparam logic [15:0] ACC_LAST = 16'(ACCEL - 1);
   localparam logic [15:0] DEC_LAST = 16'(DECEL - 1);
   localparam logic [15:0] REC_LAST = 16'(RECTIME - 1);

   typedef enum logic [2:0] {S_IDLE, S_ACCEL, S_MOVE, S_DECEL, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  fun_q, fun_d;
   logic [15:0] cnt_q, cnt_d, pos_q, pos_d, fc_q, fc_d;
   logic        tm_q, tm_d, ilf_q, ilf_d, nef_q, nef_d, fce_q, fce_d, offl_q, offl_d;
   logic [15:0] pos_inc, pos_dec, pos_nxt, fc_inc;
   logic        motion, stop;

   always_comb begin
      state_d = state_q;
      fun_d   = fun_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      fc_d    = fc_q;
      tm_d    = tm_q;
      ilf_d   = ilf_q;
      nef_d   = nef_q;
      fce_d   = fce_q;
      offl_d  = 1'b0;
      pos_inc = (pos_q == 16'hFFFF) ? pos_q : pos_q + 16'd1;
      pos_dec = (pos_q == 16'd0) ? pos_q : pos_q - 16'd1;
      pos_nxt = (fun_q == F_SPCREV) ? pos_dec : pos_inc;
      fc_inc  = fc_q + 16'd1;
      stop    = (fc_inc == 16'd0) || mtTMREC || (fun_q == F_SPCREV && pos_nxt == 16'd0);
      motion  = mtFUN == F_UNLOAD || mtFUN == F_REWIND || mtFUN == F_ERASE ||
                mtFUN == F_WRTM || mtFUN == F_SPCFWD || mtFUN == F_SPCREV;

      if (mtINIT) begin
         state_d = S_IDLE;
         fc_d    = 16'd0;
         tm_d    = 1'b0;
         ilf_d   = 1'b0;
         nef_d   = 1'b0;
         fce_d   = 1'b0;
      end else if ((state_q == S_ACCEL || state_q == S_MOVE || state_q == S_DECEL) && !mtMOL) begin
         // medium dropped mid-operation: position is lost
         state_d = S_DONE;
         pos_d   = 16'd0;
         nef_d   = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (mtGO && !mtFUN[4] && mtFUN != F_NOP) begin
               if (mtFUN == F_DRVCLR) begin
                  tm_d  = 1'b0;
                  ilf_d = 1'b0;
                  nef_d = 1'b0;
                  fce_d = 1'b0;
               end else if (!motion) begin
                  ilf_d   = 1'b1;
                  state_d = S_DONE;
               end else if (!mtMOL || (mtWRL && (mtFUN == F_ERASE || mtFUN == F_WRTM))) begin
                  nef_d   = 1'b1;
                  state_d = S_DONE;
               end else if (mtFUN == F_SPCREV && pos_q == 16'd0) begin
                  state_d = S_DONE;
               end else begin
                  fun_d   = mtFUN;
                  tm_d    = 1'b0;
                  cnt_d   = 16'd0;
                  state_d = S_ACCEL;
                  if (mtFUN == F_SPCFWD || mtFUN == F_SPCREV) fc_d = mtFCIN;
               end
            end
            S_ACCEL: begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == ACC_LAST) begin
                  cnt_d   = 16'd0;
                  state_d = S_MOVE;
               end
            end
            S_MOVE: begin
               cnt_d = cnt_q + 16'd1;
               case (fun_q)
                  F_UNLOAD, F_REWIND: begin
                     pos_d = pos_dec;
                     if (pos_q <= 16'd1) begin
                        cnt_d   = 16'd0;
                        state_d = S_DECEL;
                     end
                  end
                  F_ERASE, F_WRTM: if (cnt_q == REC_LAST) begin
                     pos_d   = pos_inc;
                     tm_d    = tm_q | (fun_q == F_WRTM);
                     cnt_d   = 16'd0;
                     state_d = S_DECEL;
                  end
                  default: if (cnt_q == REC_LAST) begin
                     // record boundary: advance, then decide whether to stop
                     cnt_d = 16'd0;
                     pos_d = pos_nxt;
                     fc_d  = fc_inc;
                     tm_d  = tm_q | mtTMREC;
                     if (stop) state_d = S_DECEL;
                     if (fun_q == F_SPCREV && pos_nxt == 16'd0 && fc_inc != 16'd0) fce_d = 1'b1;
                  end
               endcase
            end
            S_DECEL: begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == DEC_LAST) begin
                  state_d = S_DONE;
                  offl_d  = (fun_q == F_UNLOAD);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         fun_q   <= F_NOP;
         cnt_q   <= 16'd0;
         pos_q   <= 16'd0;
         fc_q    <= 16'd0;
         tm_q    <= 1'b0;
         ilf_q   <= 1'b0;
         nef_q   <= 1'b0;
         fce_q   <= 1'b0;
         offl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fun_q   <= fun_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         fc_q    <= fc_d;
         tm_q    <= tm_d;
         ilf_q   <= ilf_d;
         nef_q   <= nef_d;
         fce_q   <= fce_d;
         offl_q  <= offl_d;
      end
   end

   assign mtDRY  = (state_q == S_IDLE);
   assign mtSDWN = (state_q == S_DECEL);
   assign mtPIP  = (state_q == S_ACCEL || state_q == S_MOVE || state_q == S_DECEL) &&
                   (fun_q == F_UNLOAD || fun_q == F_REWIND);
   assign mtDONE = (state_q == S_DONE);
   assign mtOFFL = offl_q;
   assign mtBOT  = mtMOL & (pos_q == 16'd0);
   assign mtEOT  = mtMOL & (pos_q >= 16'(EOTPOS));
   assign mtTM   = tm_q;
   assign mtFC   = fc_q;
   assign mtPOS  = pos_q;
   assign mtILF  = ilf_q;
   assign mtNEF  = nef_q;
   assign mtFCE  = fce_q;

endmodule

// File: tb/tb_mt_motion_ctrl.sv
// Bench for mt_motion_ctrl: each command expands into its expected per-cycle
// output trajectory, which a compare process checks on every clock.
module tb_mt_motion_ctrl;

   localparam int ACC = 4, DEC = 3, RT = 8, EOTP = 20;

   logic        clk = 1'b0, rst;
   logic        mtINIT, mtGO, mtMOL, mtWRL, mtTMREC;
   logic [4:0]  mtFUN;
   logic [15:0] mtFCIN;
   logic        mtDRY, mtPIP, mtSDWN, mtBOT, mtEOT, mtTM, mtILF, mtNEF, mtFCE, mtDONE, mtOFFL;
   logic [15:0] mtFC, mtPOS;

   mt_motion_ctrl #(.ACCEL(ACC), .DECEL(DEC), .RECTIME(RT), .EOTPOS(EOTP)) dut (
      .clk(clk), .rst(rst), .mtINIT(mtINIT), .mtGO(mtGO), .mtFUN(mtFUN), .mtFCIN(mtFCIN),
      .mtMOL(mtMOL), .mtWRL(mtWRL), .mtTMREC(mtTMREC), .mtDRY(mtDRY), .mtPIP(mtPIP),
      .mtSDWN(mtSDWN), .mtBOT(mtBOT), .mtEOT(mtEOT), .mtTM(mtTM), .mtFC(mtFC), .mtPOS(mtPOS),
      .mtILF(mtILF), .mtNEF(mtNEF), .mtFCE(mtFCE), .mtDONE(mtDONE), .mtOFFL(mtOFFL));

   always #5 clk = ~clk;

   typedef struct packed {
      logic dry, pip, sdwn, done, offl, bot, eot, tm, ilf, nef, fce;
      logic [15:0] pos, fc;
   } snap_t;

   snap_t exp_q[$];
   snap_t traj[$];
   int    n_chk = 0, n_fail = 0;
   logic [15:0] m_pos = 0, m_fc = 0;
   logic  m_tm = 0, m_ilf = 0, m_nef = 0, m_fce = 0;

   // compare process: one expected snapshot per clock when one is queued
   initial forever begin
      snap_t a, e;
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {mtDRY, mtPIP, mtSDWN, mtDONE, mtOFFL, mtBOT, mtEOT, mtTM, mtILF, mtNEF, mtFCE, mtPOS, mtFC};
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL outputs t=%0t got %h want %h (dry,pip,sdwn,done,offl,bot,eot,tm,ilf,nef,fce,pos,fc)",
                     $time, a, e);
         end
      end
   end

   function automatic snap_t idle_snap();
      snap_t s = '0;
      s.dry = 1'b1; s.pos = m_pos; s.fc = m_fc;
      s.tm = m_tm; s.ilf = m_ilf; s.nef = m_nef; s.fce = m_fce;
      return s;
   endfunction

   task automatic push(input snap_t e);
      e.bot = mtMOL && e.pos == 16'd0;
      e.eot = mtMOL && e.pos >= 16'(EOTP);
      exp_q.push_back(e);
   endtask

   task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Expected outputs after each clock, starting with the edge that samples GO.
   task automatic build(input int code, input logic [15:0] fcin, input int tmk);
      snap_t s;
      bit    motion, space, rev;
      int    rec;
      logic [15:0] p0;
      s = idle_snap();
      traj.delete();
      motion = code inside {1, 3, 10, 11, 12, 13};
      space  = code inside {12, 13};
      rev    = (code == 13);
      if (code == 0 || code >= 16) traj.push_back(s);
      else if (code == 4) begin
         s.tm = 0; s.ilf = 0; s.nef = 0; s.fce = 0;
         traj.push_back(s);
      end else if (!motion || !mtMOL || (mtWRL && code inside {10, 11}) || (rev && m_pos == 0)) begin
         if (!motion) s.ilf = 1;
         else if (!mtMOL || (mtWRL && code inside {10, 11})) s.nef = 1;
         s.dry = 0; s.done = 1; traj.push_back(s);
         s.dry = 1; s.done = 0; traj.push_back(s);
      end else begin
         s.dry = 0; s.pip = (code <= 3); s.tm = 0;
         if (space) s.fc = fcin;
         repeat (ACC) traj.push_back(s);
         if (code <= 3) begin
            p0 = s.pos;
            for (int k = 0; k < ((p0 == 0) ? 1 : int'(p0)); k++) begin
               s.pos = p0 - 16'(k);
               traj.push_back(s);
            end
            s.pos = 0;
         end else if (!space) begin
            repeat (RT) traj.push_back(s);
            if (s.pos != 16'hFFFF) s.pos++;
            if (code == 11) s.tm = 1;
         end else begin
            rec = 0;
            forever begin
               repeat (RT) traj.push_back(s);
               rec++;
               s.fc++;
               if (rev) s.pos = (s.pos == 0) ? 16'd0 : s.pos - 1;
               else if (s.pos != 16'hFFFF) s.pos++;
               if (rec == tmk) s.tm = 1;
               if (s.fc == 0 || rec == tmk || (rev && s.pos == 0)) begin
                  if (rev && s.pos == 0 && s.fc != 0) s.fce = 1;
                  break;
               end
            end
         end
         s.sdwn = 1; repeat (DEC) traj.push_back(s);
         s.sdwn = 0; s.pip = 0; s.done = 1; s.offl = (code == 1); traj.push_back(s);
         s.done = 0; s.offl = 0; s.dry = 1; traj.push_back(s);
      end
   endtask

   // abk: 0 none, 1 INIT, 2 medium drop; abat<0 picks a random in-motion cycle
   task automatic run_cmd(input int code, input logic [15:0] fcin, input int tmk,
                          input int abk, input int abat, input bit junk);
      snap_t e, prev, last;
      bit    rend;
      int    ab, at;
      build(code, fcin, tmk);
      ab = abk; at = abat;
      if (traj.size() <= 4) ab = 0;
      else if (at < 0) at = $urandom_range(1, traj.size() - 3);
      last = idle_snap();
      for (int i = 0; i < traj.size(); i++) begin
         @(negedge clk);
         mtGO = (i == 0); mtFUN = 5'(code); mtFCIN = fcin; mtINIT = 0;
         rend = (i > ACC) && ((i - ACC) % RT == 0);
         mtTMREC = rend ? (tmk > 0 && i == ACC + tmk * RT) : 1'($urandom % 2);
         if (junk && i > 0 && !traj[i-1].dry && $urandom % 5 == 0) begin
            mtGO = 1; mtFUN = 5'($urandom); mtFCIN = 16'($urandom);
         end
         e = traj[i];
         if (ab != 0 && i == at) begin
            prev = traj[i-1];
            e = prev;
            if (ab == 1) begin
               mtINIT = 1;
               e.dry = 1; e.pip = 0; e.sdwn = 0; e.done = 0; e.offl = 0;
               e.fc = 0; e.tm = 0; e.ilf = 0; e.nef = 0; e.fce = 0;
            end else begin
               mtMOL = 0;
               e.dry = 0; e.pip = 0; e.sdwn = 0; e.done = 1; e.offl = 0; e.pos = 0; e.nef = 1;
            end
            push(e);
            @(negedge clk);
            mtGO = 0; mtINIT = 0; mtMOL = 1; mtTMREC = 0;
            e.done = 0; e.dry = 1;
            push(e); last = e;
            break;
         end
         push(e); last = e;
      end
      @(negedge clk);
      mtGO = 0; mtINIT = 0; mtTMREC = 0;
      m_pos = last.pos; m_fc = last.fc; m_tm = last.tm;
      m_ilf = last.ilf; m_nef = last.nef; m_fce = last.fce;
   endtask

   initial begin
      int codes[12] = '{0, 1, 3, 4, 7, 10, 11, 12, 13, 20, 2, 31};
      int n;
      rst = 1; mtINIT = 0; mtGO = 0; mtFUN = 0; mtFCIN = 0; mtMOL = 1; mtWRL = 0; mtTMREC = 0;
      repeat (2) begin
         @(negedge clk);
         push(idle_snap());
      end
      @(negedge clk);
      rst = 0;
      lit("reset_dry", 16'(mtDRY), 16'd1);
      lit("reset_pos", mtPOS, 16'd0);
      lit("reset_done", 16'(mtDONE), 16'd0);

      run_cmd(12, 16'hFFFD, 0, 0, 0, 0);
      lit("s48_pos", mtPOS, 16'd3);
      lit("s48_fc", mtFC, 16'd0);
      lit("s48_dry", 16'(mtDRY), 16'd1);

      run_cmd(12, 16'hFFFE, 0, 0, 0, 0);
      lit("pos5", mtPOS, 16'd5);
      run_cmd(13, 16'hFFF6, 0, 0, 0, 0);
      lit("s49_pos", mtPOS, 16'd0);
      lit("s49_bot", 16'(mtBOT), 16'd1);
      lit("s49_fce", 16'(mtFCE), 16'd1);
      lit("s49_fc", mtFC, 16'hFFFB);

      run_cmd(4, 16'd0, 0, 0, 0, 0);
      run_cmd(12, 16'hFFF0, 2, 0, 0, 0);
      lit("s50_pos", mtPOS, 16'd2);
      lit("s50_tm", 16'(mtTM), 16'd1);
      lit("s50_fc", mtFC, 16'hFFF2);

      mtWRL = 1;
      run_cmd(11, 16'd0, 0, 0, 0, 0);
      lit("s51_nef", 16'(mtNEF), 16'd1);
      lit("s51_pos", mtPOS, 16'd2);
      run_cmd(4, 16'd0, 0, 0, 0, 0);
      lit("s51_clr", 16'(mtNEF), 16'd0);
      mtWRL = 0;

      run_cmd(12, 16'hFFF8, 0, 0, 0, 0);
      lit("pos10", mtPOS, 16'd10);
      run_cmd(1, 16'd0, 0, 0, 0, 1);
      lit("s52_pos", mtPOS, 16'd0);

      run_cmd(7, 16'd0, 0, 0, 0, 0);
      lit("s53_ilf", 16'(mtILF), 16'd1);
      run_cmd(12, 16'hFFFA, 0, 1, ACC + 10, 0);
      lit("s53_dry", 16'(mtDRY), 16'd1);
      lit("s53_pos", mtPOS, 16'd1);
      lit("s53_ilf", 16'(mtILF), 16'd0);

      run_cmd(10, 16'd0, 0, 2, ACC, 0);
      lit("moldrop_pos", mtPOS, 16'd0);
      lit("moldrop_nef", 16'(mtNEF), 16'd1);
      run_cmd(4, 16'd0, 0, 0, 0, 0);

      run_cmd(12, 16'hFFEA, 0, 0, 0, 0);
      lit("eot_pos", mtPOS, 16'd22);
      lit("eot_flag", 16'(mtEOT), 16'd1);
      run_cmd(3, 16'd0, 0, 0, 0, 1);
      lit("rewind_pos", mtPOS, 16'd0);

      for (int t = 0; t < 80; t++) begin
         mtMOL = ($urandom % 10) != 0;
         mtWRL = ($urandom % 4) == 0;
         n = $urandom_range(1, 6);
         run_cmd(codes[$urandom % 12], 16'(-n), $urandom_range(0, 7),
                 ($urandom % 8 == 0) ? $urandom_range(1, 2) : 0, -1, 1);
      end
      mtMOL = 1;
      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
